// File: rtl/apb_bridge_fsm.sv
// AHB-to-APB bridge. One AHB transfer at a time is converted into an APB
// SETUP/ACCESS sequence. All outputs come straight from registers. A wait
// counter bounds ACCESS, and a two-cycle ERROR response is returned on
// pslverr or timeout.
module apb_bridge_fsm #(
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic            valid,
  input  logic [31:0]     haddr,
  input  logic            hwrite,
  input  logic [31:0]     hwdata,
  output logic            hreadyout,
  output logic [1:0]      hresp,
  output logic [31:0]     hrdata,
  output logic [31:0]     paddr,
  output logic [31:0]     pwdata,
  output logic            pwrite,
  output logic [NSLV-1:0] psel,
  output logic            penable,
  input  logic [31:0]     prdata,
  input  logic            pready,
  input  logic            pslverr
);

  localparam int         SW     = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_t;

  // One-hot slave select from the slave-index field of the address.
  function automatic logic [NSLV-1:0] sel_decode(input logic [SW-1:0] idx);
    logic [NSLV-1:0] oh;
    oh      = {NSLV{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

  state_t          state_r, state_n;
  logic [31:0]     paddr_r, paddr_n;
  logic [31:0]     pwdata_r, pwdata_n;
  logic            pwrite_r, pwrite_n;
  logic [NSLV-1:0] psel_r, psel_n;
  logic            penable_r, penable_n;
  logic            hreadyout_r, hreadyout_n;
  logic [1:0]      hresp_r, hresp_n;
  logic [31:0]     hrdata_r, hrdata_n;
  logic [7:0]      wcnt_r, wcnt_n;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_n     = state_r;
    paddr_n     = paddr_r;
    pwdata_n    = pwdata_r;
    pwrite_n    = pwrite_r;
    psel_n      = psel_r;
    penable_n   = penable_r;
    hreadyout_n = hreadyout_r;
    hresp_n     = hresp_r;
    hrdata_n    = hrdata_r;
    wcnt_n      = wcnt_r;
    case (state_r)
      S_IDLE: begin
        hreadyout_n = 1'b1;
        hresp_n     = 2'b00;
        psel_n      = {NSLV{1'b0}};
        penable_n   = 1'b0;
        if (valid) begin
          paddr_n     = haddr;
          pwrite_n    = hwrite;
          hreadyout_n = 1'b0;
          if (hwrite) begin
            state_n = S_WDATA;
          end else begin
            // Reads go straight to SETUP, so select the slave now.
            state_n = S_SETUP;
            psel_n  = sel_decode(haddr[SEL_LSB +: SW]);
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WDATA: begin
        pwdata_n = hwdata;
        psel_n   = sel_decode(paddr_r[SEL_LSB +: SW]);
        state_n  = S_SETUP;
      end
      S_SETUP: begin
        penable_n = 1'b1;
        wcnt_n    = 8'd0;
        state_n   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          psel_n    = {NSLV{1'b0}};
          penable_n = 1'b0;
          if (pslverr) begin
            state_n = S_ERR1;
            hresp_n = 2'b01;
          end else begin
            state_n     = S_IDLE;
            hreadyout_n = 1'b1;
            hresp_n     = 2'b00;
            if (!pwrite_r) begin
              hrdata_n = prdata;
            end else begin
              hrdata_n = hrdata_r;
            end
          end
        end else if (wcnt_r + 8'd1 == TO_LIM) begin
          // Slave never answered: abandon the APB transfer.
          wcnt_n    = wcnt_r + 8'd1;
          psel_n    = {NSLV{1'b0}};
          penable_n = 1'b0;
          hresp_n   = 2'b01;
          state_n   = S_ERR1;
        end else begin
          wcnt_n = wcnt_r + 8'd1;
        end
      end
      S_ERR1: begin
        hreadyout_n = 1'b1;
        hresp_n     = 2'b01;
        state_n     = S_ERR2;
      end
      S_ERR2: begin
        // The master cancels after an error, so valid is not looked at here.
        hreadyout_n = 1'b1;
        hresp_n     = 2'b00;
        state_n     = S_IDLE;
      end
      default: begin
        state_n     = S_IDLE;
        psel_n      = {NSLV{1'b0}};
        penable_n   = 1'b0;
        hreadyout_n = 1'b1;
        hresp_n     = 2'b00;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r     <= S_IDLE;
      paddr_r     <= 32'd0;
      pwdata_r    <= 32'd0;
      pwrite_r    <= 1'b0;
      psel_r      <= {NSLV{1'b0}};
      penable_r   <= 1'b0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 2'b00;
      hrdata_r    <= 32'd0;
      wcnt_r      <= 8'd0;
    end else begin
      state_r     <= state_n;
      paddr_r     <= paddr_n;
      pwdata_r    <= pwdata_n;
      pwrite_r    <= pwrite_n;
      psel_r      <= psel_n;
      penable_r   <= penable_n;
      hreadyout_r <= hreadyout_n;
      hresp_r     <= hresp_n;
      hrdata_r    <= hrdata_n;
      wcnt_r      <= wcnt_n;
    end
  end

  assign paddr     = paddr_r;
  assign pwdata    = pwdata_r;
  assign pwrite    = pwrite_r;
  assign psel      = psel_r;
  assign penable   = penable_r;
  assign hreadyout = hreadyout_r;
  assign hresp     = hresp_r;
  assign hrdata    = hrdata_r;

endmodule
